mips_memory_stage: RTL and testbench

MEM stage of the 5-stage MIPS pipeline, between the EX/MEM register and write-back. It holds a byte-addressable data memory, performs sized loads and stores selected by opcode, and resolves BEQ/BNE branch decisions into PC-select and flush signals. It also registers the MEM/WB pipeline fields, gated by the debug execution mode (continuous or single-step).

---
 rtl/mips_memory_stage.sv | 179 +++++++++++++++++
 tb/tb_mips_memory_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_memory_stage.sv
// MEM stage: byte-addressable data memory, sized loads/stores,
// BEQ/BNE resolution and the MEM/WB register with step-mode gating.
module mips_memory_stage #(
    parameter int NB_DATA   = 32,
    parameter int NB_BYTE   = 8,
    parameter int NB_REG    = 5,
    parameter int NB_OPCODE = 6,
    parameter int MEM_WORDS = 64
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic                 i_exec_mode,
    input  logic                 i_step,
    input  logic                 i_branch,
    input  logic                 i_jump,
    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  logic                 i_mem_to_reg,
    input  logic                 i_reg_write,
    input  logic                 i_halt,
    input  logic [NB_OPCODE-1:0] i_opcode,
    input  logic [NB_DATA-1:0]   i_pc_4,
    input  logic [NB_DATA-1:0]   i_pc_branch,
    input  logic                 i_zero,
    input  logic [NB_DATA-1:0]   i_alu_result,
    input  logic [NB_DATA-1:0]   i_read_data_2,
    input  logic [NB_REG-1:0]    i_rt_rd,
    output logic                 o_pc_src,
    output logic                 o_jump,
    output logic                 o_flush,
    output logic                 o_mem_to_reg,
    output logic                 o_reg_write,
    output logic                 o_halt,
    output logic [NB_DATA-1:0]   o_pc_4,
    output logic [NB_DATA-1:0]   o_read_data,
    output logic [NB_DATA-1:0]   o_alu_result,
    output logic [NB_REG-1:0]    o_rt_rd
);

    localparam int NB_IDX  = $clog2(MEM_WORDS);
    localparam int NB_ADDR = NB_IDX + 2;
    localparam int NB_HALF = 2 * NB_BYTE;

    localparam logic [NB_OPCODE-1:0] OP_LB  = 6'b100000;
    localparam logic [NB_OPCODE-1:0] OP_LH  = 6'b100001;
    localparam logic [NB_OPCODE-1:0] OP_LW  = 6'b100011;
    localparam logic [NB_OPCODE-1:0] OP_LBU = 6'b100100;
    localparam logic [NB_OPCODE-1:0] OP_LHU = 6'b100101;
    localparam logic [NB_OPCODE-1:0] OP_LWU = 6'b100111;
    localparam logic [NB_OPCODE-1:0] OP_SB  = 6'b101000;
    localparam logic [NB_OPCODE-1:0] OP_SH  = 6'b101001;
    localparam logic [NB_OPCODE-1:0] OP_BNE = 6'b000101;

    logic                en;
    logic                we;
    logic [NB_ADDR-1:0]  addr;
    logic [NB_IDX-1:0]   idx;
    logic [NB_DATA-1:0]  rd_word;
    logic [NB_BYTE-1:0]  rd_byte;
    logic [NB_HALF-1:0]  rd_half;
    logic [NB_DATA-1:0]  load_data;
    logic [NB_DATA-1:0]  wr_word;
    logic                unused_bits;

    logic [NB_DATA-1:0]  mem_q [MEM_WORDS];

    logic                mem_to_reg_q, mem_to_reg_d;
    logic                reg_write_q, reg_write_d;
    logic                halt_q, halt_d;
    logic [NB_DATA-1:0]  pc_4_q, pc_4_d;
    logic [NB_DATA-1:0]  read_data_q, read_data_d;
    logic [NB_DATA-1:0]  alu_result_q, alu_result_d;
    logic [NB_REG-1:0]   rt_rd_q, rt_rd_d;

    assign en   = i_valid & (~i_exec_mode | i_step);
    assign we   = en & i_mem_write;
    assign addr = i_alu_result[NB_ADDR-1:0];
    assign idx  = addr[NB_ADDR-1:2];

    // Upper address bits wrap; the branch target is consumed by fetch.
    assign unused_bits = ^{i_pc_branch, i_alu_result[NB_DATA-1:NB_ADDR]};

    assign rd_word = mem_q[idx];
    assign rd_byte = rd_word[addr[1:0]*NB_BYTE +: NB_BYTE];
    assign rd_half = rd_word[addr[1]*NB_HALF +: NB_HALF];

    always_comb begin
        load_data = '0;
        if (i_mem_read) begin
            unique case (i_opcode)
                OP_LB:   load_data = {{(NB_DATA-NB_BYTE){rd_byte[NB_BYTE-1]}},
                                      rd_byte};
                OP_LH:   load_data = {{(NB_DATA-NB_HALF){rd_half[NB_HALF-1]}},
                                      rd_half};
                OP_LBU:  load_data = {{(NB_DATA-NB_BYTE){1'b0}}, rd_byte};
                OP_LHU:  load_data = {{(NB_DATA-NB_HALF){1'b0}}, rd_half};
                OP_LW,
                OP_LWU:  load_data = rd_word;
                default: load_data = rd_word;
            endcase
        end
    end

    // Merge store data into the current word so unselected lanes survive.
    always_comb begin
        wr_word = rd_word;
        unique case (i_opcode)
            OP_SB:   wr_word[addr[1:0]*NB_BYTE +: NB_BYTE] =
                         i_read_data_2[NB_BYTE-1:0];
            OP_SH:   wr_word[addr[1]*NB_HALF +: NB_HALF] =
                         i_read_data_2[NB_HALF-1:0];
            default: wr_word = i_read_data_2;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[idx] <= wr_word;
        end
    end

    always_comb begin
        mem_to_reg_d = mem_to_reg_q;
        reg_write_d  = reg_write_q;
        halt_d       = halt_q;
        pc_4_d       = pc_4_q;
        read_data_d  = read_data_q;
        alu_result_d = alu_result_q;
        rt_rd_d      = rt_rd_q;
        if (en) begin
            mem_to_reg_d = i_mem_to_reg;
            reg_write_d  = i_reg_write;
            halt_d       = i_halt;
            pc_4_d       = i_pc_4;
            read_data_d  = load_data;
            alu_result_d = i_alu_result;
            rt_rd_d      = i_rt_rd;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            halt_q       <= 1'b0;
            pc_4_q       <= '0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            rt_rd_q      <= '0;
        end else begin
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            halt_q       <= halt_d;
            pc_4_q       <= pc_4_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            rt_rd_q      <= rt_rd_d;
        end
    end

    assign o_pc_src = i_valid & i_branch &
                      ((i_opcode == OP_BNE) ? ~i_zero : i_zero);
    assign o_jump   = i_jump & i_valid;
    assign o_flush  = o_pc_src | o_jump;

    assign o_mem_to_reg = mem_to_reg_q;
    assign o_reg_write  = reg_write_q;
    assign o_halt       = halt_q;
    assign o_pc_4       = pc_4_q;
    assign o_read_data  = read_data_q;
    assign o_alu_result = alu_result_q;
    assign o_rt_rd      = rt_rd_q;

endmodule

// File: tb/tb_mips_memory_stage.sv
// Bench for mips_memory_stage: directed scenarios, then random
// traffic against a byte-array reference model.
module tb_mips_memory_stage;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] LWU = 6'b100111;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, exec_mode, step;
    logic        branch, jump, mem_read, mem_write;
    logic        mem_to_reg, reg_write, halt, zero;
    logic [5:0]  opcode;
    logic [31:0] pc_4, pc_branch, alu, wdata;
    logic [4:0]  rt_rd;

    logic        o_pc_src, o_jump, o_flush;
    logic        o_mem_to_reg, o_reg_write, o_halt;
    logic [31:0] o_pc_4, o_read_data, o_alu_result;
    logic [4:0]  o_rt_rd;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  m [256];
    logic        e_m2r, e_rw, e_halt;
    logic [31:0] e_pc4, e_rd, e_alu;
    logic [4:0]  e_rt;

    always #5 clk = ~clk;

    mips_memory_stage dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_valid      (valid),
        .i_exec_mode  (exec_mode),
        .i_step       (step),
        .i_branch     (branch),
        .i_jump       (jump),
        .i_mem_read   (mem_read),
        .i_mem_write  (mem_write),
        .i_mem_to_reg (mem_to_reg),
        .i_reg_write  (reg_write),
        .i_halt       (halt),
        .i_opcode     (opcode),
        .i_pc_4       (pc_4),
        .i_pc_branch  (pc_branch),
        .i_zero       (zero),
        .i_alu_result (alu),
        .i_read_data_2(wdata),
        .i_rt_rd      (rt_rd),
        .o_pc_src     (o_pc_src),
        .o_jump       (o_jump),
        .o_flush      (o_flush),
        .o_mem_to_reg (o_mem_to_reg),
        .o_reg_write  (o_reg_write),
        .o_halt       (o_halt),
        .o_pc_4       (o_pc_4),
        .o_read_data  (o_read_data),
        .o_alu_result (o_alu_result),
        .o_rt_rd      (o_rt_rd)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(logic [5:0] op, logic [31:0] a);
        int b, h, w;
        logic [31:0] word;
        logic [15:0] half;
        b = int'(a[7:0]);
        h = b - (b % 2);
        w = b - (b % 4);
        half = {m[h+1], m[h]};
        word = {m[w+3], m[w+2], m[w+1], m[w]};
        case (op)
            LB:      return {{24{m[b][7]}}, m[b]};
            LBU:     return {24'h0, m[b]};
            LH:      return {{16{half[15]}}, half};
            LHU:     return {16'h0, half};
            default: return word;
        endcase
    endfunction

    task automatic ref_store(logic [5:0] op, logic [31:0] a, logic [31:0] d);
        int b;
        b = int'(a[7:0]);
        if (op == SB) begin
            m[b] = d[7:0];
        end else if (op == SH) begin
            b = b - (b % 2);
            m[b] = d[7:0];
            m[b+1] = d[15:8];
        end else begin
            b = b - (b % 4);
            for (int k = 0; k < 4; k++) m[b+k] = d[8*k +: 8];
        end
    endtask

    task automatic idle();
        valid = 1'b1; exec_mode = 1'b0; step = 1'b0;
        branch = 1'b0; jump = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_to_reg = 1'b0; reg_write = 1'b0; halt = 1'b0; zero = 1'b0;
        opcode = 6'h0; pc_4 = 32'h0; pc_branch = 32'h0;
        alu = 32'h0; wdata = 32'h0; rt_rd = 5'h0;
    endtask

    // Inputs are driven just after a falling edge; one full cycle follows.
    task automatic tick();
        logic [31:0] ld;
        logic        en, src;
        #1;
        src = valid && branch && ((opcode == BNE) ? !zero : zero);
        chk("pc_src", {31'h0, o_pc_src}, {31'h0, src});
        chk("jump", {31'h0, o_jump}, {31'h0, valid && jump});
        chk("flush", {31'h0, o_flush}, {31'h0, src || (valid && jump)});
        ld = mem_read ? ref_load(opcode, alu) : 32'h0;
        en = valid && (!exec_mode || step);
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) m[i] = 8'h0;
            {e_m2r, e_rw, e_halt} = 3'b000;
            e_pc4 = 0; e_rd = 0; e_alu = 0; e_rt = 0;
        end else if (en) begin
            if (mem_write) ref_store(opcode, alu, wdata);
            e_m2r = mem_to_reg; e_rw = reg_write; e_halt = halt;
            e_pc4 = pc_4; e_rd = ld; e_alu = alu; e_rt = rt_rd;
        end
        @(negedge clk);
        chk("mem_to_reg", {31'h0, o_mem_to_reg}, {31'h0, e_m2r});
        chk("reg_write", {31'h0, o_reg_write}, {31'h0, e_rw});
        chk("halt", {31'h0, o_halt}, {31'h0, e_halt});
        chk("pc_4", o_pc_4, e_pc4);
        chk("read_data", o_read_data, e_rd);
        chk("alu_result", o_alu_result, e_alu);
        chk("rt_rd", {27'h0, o_rt_rd}, {27'h0, e_rt});
    endtask

    task automatic mem_op(logic rd, logic wr, logic [5:0] op,
                          logic [31:0] a, logic [31:0] d);
        idle();
        mem_read = rd; mem_write = wr; opcode = op; alu = a; wdata = d;
        tick();
    endtask

    logic [5:0] ops [12];

    initial begin
        ops = '{LB, LH, LW, LBU, LHU, LWU, SB, SH, SW, BEQ, BNE, 6'h3f};
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_alu", o_alu_result, 32'h0);
        rst_n = 1'b1;

        mem_op(1, 0, LW, $urandom, 0);
        chk("rst_lw", o_read_data, 32'h0);

        mem_op(0, 1, SW, 32'h10, 32'hDEADBEEF);
        mem_op(1, 0, LW, 32'h10, 0);
        chk("lw_10", o_read_data, 32'hDEADBEEF);
        mem_op(1, 0, LW, 32'h110, 0);
        chk("lw_wrap", o_read_data, 32'hDEADBEEF);

        mem_op(0, 1, SW, 32'h20, 32'h80FF7F01);
        mem_op(0, 1, SB, 32'h21, 32'h000000AA);
        mem_op(1, 0, LW, 32'h20, 0);
        chk("sb_lw", o_read_data, 32'h80FFAA01);
        mem_op(1, 0, LB, 32'h23, 0);
        chk("lb", o_read_data, 32'hFFFFFF80);
        mem_op(1, 0, LBU, 32'h23, 0);
        chk("lbu", o_read_data, 32'h00000080);
        mem_op(1, 0, LH, 32'h22, 0);
        chk("lh", o_read_data, 32'hFFFF80FF);
        mem_op(1, 0, LHU, 32'h22, 0);
        chk("lhu", o_read_data, 32'h000080FF);

        idle(); opcode = BEQ; branch = 1; zero = 1; #1;
        chk("beq_src", {31'h0, o_pc_src}, 32'h1);
        chk("beq_flush", {31'h0, o_flush}, 32'h1);
        tick();
        idle(); opcode = BNE; branch = 1; zero = 1; #1;
        chk("bne_src", {31'h0, o_pc_src}, 32'h0);
        tick();
        idle(); jump = 1; #1;
        chk("j_jump", {31'h0, o_jump}, 32'h1);
        chk("j_flush", {31'h0, o_flush}, 32'h1);
        tick();

        idle(); exec_mode = 1; mem_write = 1; opcode = SW;
        alu = 32'h30; wdata = 32'h55;
        tick();
        chk("step_hold", o_alu_result, 32'h0);
        idle(); exec_mode = 1; step = 1; mem_read = 1; opcode = LW; alu = 32'h30;
        tick();
        chk("step_nostore", o_read_data, 32'h0);
        idle(); exec_mode = 1; step = 1; mem_write = 1; opcode = SW;
        alu = 32'h30; wdata = 32'h55;
        tick();
        idle(); exec_mode = 1; step = 1; mem_read = 1; opcode = LW; alu = 32'h30;
        tick();
        chk("step_store", o_read_data, 32'h55);
        idle(); exec_mode = 1; step = 1; alu = 32'h7;
        tick();
        chk("step_alu", o_alu_result, 32'h7);

        idle(); reg_write = 1; mem_to_reg = 1; halt = 1; rt_rd = 5'd31;
        pc_4 = 32'h44;
        tick();
        chk("pt_rt", {27'h0, o_rt_rd}, 32'd31);
        chk("pt_pc4", o_pc_4, 32'h44);
        chk("pt_halt", {31'h0, o_halt}, 32'h1);

        for (int n = 0; n < 600; n++) begin
            idle();
            rst_n      = ($urandom % 64) != 0;
            valid      = ($urandom % 8) != 0;
            exec_mode  = ($urandom % 4) == 0;
            step       = $urandom % 2;
            branch     = $urandom % 2;
            jump       = ($urandom % 4) == 0;
            zero       = $urandom % 2;
            mem_read   = $urandom % 2;
            mem_write  = $urandom % 2;
            mem_to_reg = $urandom % 2;
            reg_write  = $urandom % 2;
            halt       = $urandom % 2;
            opcode     = ops[$urandom_range(0, 11)];
            alu        = ($urandom % 2) ? $urandom : $urandom_range(0, 63);
            wdata      = $urandom;
            pc_4       = $urandom;
            pc_branch  = $urandom;
            rt_rd      = 5'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
